// File: rtl/count_ctrl_pkg.sv
// Shared types and BCD constants for the count_ctrl BCD up/down counter.
package count_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [7:0] TERM_UP = 8'h99;
    localparam logic [7:0] TERM_DN = 8'h00;

    function automatic logic bcd_valid(input logic [7:0] v);
        return (v[7:4] <= BCD_MAX) && (v[3:0] <= BCD_MAX);
    endfunction

endpackage

// File: rtl/count_ctrl_if.sv
// Control and status signals of count_ctrl; master drives controls, slave is the counter.
interface count_ctrl_if;
    logic       start;
    logic       pause;
    logic       load;
    logic       up;
    logic [7:0] preset;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       tick;
    logic       running;
    logic       done;

    modport master (
        output start, pause, load, up, preset,
        input  tens, ones, tick, running, done
    );

    modport slave (
        input  start, pause, load, up, preset,
        output tens, ones, tick, running, done
    );
endinterface

// File: rtl/count_ctrl_tick_gen.sv
// Period divider: tick strobes during the cycle whose rising edge wraps the divider,
// so the parent can update the count on that same edge.
module tick_gen #(
    parameter int unsigned DIV = 50000000
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic sclr,
    output logic tick
);
    localparam int unsigned W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] div;

    assign tick = en && (div == LAST);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            div <= '0;
        end else if (sclr) begin
            div <= '0;
        end else if (en) begin
            div <= tick ? '0 : div + 1'b1;
        end
    end
endmodule

// File: rtl/count_ctrl.sv
// Two-digit BCD up/down counter with IDLE/RUN/PAUSE/DONE control, one step per DIV clocks.
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int unsigned DIV = 50000000
) (
    input  logic        clk,
    input  logic        clr,
    count_ctrl_if.slave bus
);
    state_t     state;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       tick_q;
    logic       wrap;
    logic       sclr;
    logic       load_ok;
    logic [3:0] nx_tens;
    logic [3:0] nx_ones;
    logic       term;

    assign load_ok = bus.load && bcd_valid(bus.preset);

    // Divider restarts on entry from IDLE and on every accepted load; resume from PAUSE keeps it.
    always_comb begin
        sclr = 1'b0;
        case (state)
            IDLE:    sclr = bus.start || load_ok;
            PAUSE:   sclr = !(bus.start && !bus.pause) && load_ok;
            DONE:    sclr = load_ok;
            default: sclr = 1'b0;
        endcase
    end

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk  (clk),
        .clr  (clr),
        .en   (state == RUN),
        .sclr (sclr),
        .tick (wrap)
    );

    always_comb begin
        nx_tens = tens;
        nx_ones = ones;
        if (bus.up) begin
            if (ones == BCD_MAX) begin
                nx_ones = '0;
                nx_tens = (tens == BCD_MAX) ? '0 : tens + 4'd1;
            end else begin
                nx_ones = ones + 4'd1;
            end
        end else begin
            if (ones == '0) begin
                nx_ones = BCD_MAX;
                nx_tens = (tens == '0) ? BCD_MAX : tens - 4'd1;
            end else begin
                nx_ones = ones - 4'd1;
            end
        end
        term = bus.up ? ({nx_tens, nx_ones} == TERM_UP) : ({nx_tens, nx_ones} == TERM_DN);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            tens   <= '0;
            ones   <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= RUN;
                    end else if (load_ok) begin
                        {tens, ones} <= bus.preset;
                    end
                end
                RUN: begin
                    if (wrap) begin
                        tick_q <= 1'b1;
                        tens   <= nx_tens;
                        ones   <= nx_ones;
                        if (term) begin
                            state <= DONE;
                        end else if (bus.pause) begin
                            state <= PAUSE;
                        end
                    end else if (bus.pause) begin
                        state <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (bus.start && !bus.pause) begin
                        state <= RUN;
                    end else if (load_ok) begin
                        {tens, ones} <= bus.preset;
                    end
                end
                DONE: begin
                    if (load_ok) begin
                        {tens, ones} <= bus.preset;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tens    = tens;
    assign bus.ones    = ones;
    assign bus.tick    = tick_q;
    assign bus.running = (state == RUN);
    assign bus.done    = (state == DONE);
endmodule

// File: tb/tb_count_ctrl.sv
// Self-checking bench for count_ctrl (DIV=4): directed scenarios plus random stimulus vs a decimal model.
module tb_count_ctrl;
    localparam int DIVP = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic clk;
    logic clr;
    int   checks = 0;
    int   errors = 0;
    int   ticks_seen = 0;

    count_ctrl_if bus ();

    count_ctrl #(.DIV(DIVP)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: count kept as a plain integer 0..99, phase as cycles spent running.
    int m_state, m_cnt, m_phase;
    bit m_tick;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit preset_ok(input logic [7:0] p);
        return (p[7:4] < 10) && (p[3:0] < 10);
    endfunction

    function automatic int preset_val(input logic [7:0] p);
        return int'(p[7:4]) * 10 + int'(p[3:0]);
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_cnt = 0; m_phase = 0; m_tick = 0;
    endtask

    task automatic model_step();
        bit ld;
        ld = bus.load && preset_ok(bus.preset);
        m_tick = 0;
        if (clr) begin
            model_reset();
        end else begin
            case (m_state)
                M_IDLE: begin
                    if (bus.start) begin m_state = M_RUN; m_phase = 0; end
                    else if (ld) begin m_cnt = preset_val(bus.preset); m_phase = 0; end
                end
                M_RUN: begin
                    if (m_phase == DIVP - 1) begin
                        m_phase = 0;
                        m_tick  = 1;
                        m_cnt   = bus.up ? (m_cnt + 1) % 100 : (m_cnt + 99) % 100;
                        if ((bus.up && m_cnt == 99) || (!bus.up && m_cnt == 0)) m_state = M_DONE;
                        else if (bus.pause) m_state = M_PAUSE;
                    end else begin
                        m_phase++;
                        if (bus.pause) m_state = M_PAUSE;
                    end
                end
                M_PAUSE: begin
                    if (bus.start && !bus.pause) m_state = M_RUN;
                    else if (ld) begin m_cnt = preset_val(bus.preset); m_phase = 0; end
                end
                default: begin
                    if (ld) begin m_cnt = preset_val(bus.preset); m_phase = 0; m_state = M_IDLE; end
                end
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        if (bus.tick) ticks_seen++;
        check("tens", int'(bus.tens), m_cnt / 10);
        check("ones", int'(bus.ones), m_cnt % 10);
        check("tick", int'(bus.tick), int'(m_tick));
        check("running", int'(bus.running), int'(m_state == M_RUN));
        check("done", int'(bus.done), int'(m_state == M_DONE));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; step(); bus.start = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] p);
        bus.preset = p; bus.load = 1'b1; step(); bus.load = 1'b0;
    endtask

    task automatic wait_tick(input int limit, output int n);
        n = 0;
        do begin step(); n++; end while (!bus.tick && n < limit);
        if (!bus.tick) check("tick_timeout", 0, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tens"}, int'(bus.tens), 0);
        check({tag, "_ones"}, int'(bus.ones), 0);
        check({tag, "_tick"}, int'(bus.tick), 0);
        check({tag, "_running"}, int'(bus.running), 0);
        check({tag, "_done"}, int'(bus.done), 0);
    endtask

    // Asserts clr between edges and checks outputs clear before the next edge.
    task automatic do_clr();
        #2 clr = 1'b1;
        #1 check_zero("async_clr");
        model_reset();
        step();
        clr = 1'b0;
    endtask

    int n, t0;

    initial begin
        bus.start = 0; bus.pause = 0; bus.load = 0; bus.up = 1; bus.preset = 8'h00;
        clr = 1'b1;
        model_reset();
        #50 check_zero("reset");
        #50 clr = 1'b0;

        // Basic up count and first-tick latency
        bus.up = 1;
        pulse_start();
        wait_tick(20, n);
        check("first_tick_lat", n, 4);
        check("cnt01", int'({bus.tens, bus.ones}), 8'h01);
        wait_tick(20, n);
        check("tick_period", n, 4);
        check("cnt02", int'({bus.tens, bus.ones}), 8'h02);

        // Clear mid-RUN, then no ticks without a start
        steps(1);
        do_clr();
        t0 = ticks_seen;
        steps(12);
        check("no_tick_after_clr", ticks_seen - t0, 0);

        // 97 up -> 98 -> 99 DONE, then held
        do_load(8'h97);
        pulse_start();
        wait_tick(20, n);
        check("cnt98", int'({bus.tens, bus.ones}), 8'h98);
        wait_tick(20, n);
        check("cnt99", int'({bus.tens, bus.ones}), 8'h99);
        check("done_with_tick", int'(bus.done && bus.tick), 1);
        t0 = ticks_seen;
        steps(12);
        check("done_no_ticks", ticks_seen - t0, 0);
        check("done_held99", int'({bus.tens, bus.ones}), 8'h99);

        // 01 down -> 00 DONE; bad preset ignored; good preset returns to IDLE
        do_clr();
        do_load(8'h01);
        bus.up = 0;
        pulse_start();
        wait_tick(20, n);
        check("cnt00_done", int'({bus.tens, bus.ones, bus.done}), 9'h001);
        do_load(8'h3A);
        check("bad_load_done", int'(bus.done), 1);
        do_load(8'h42);
        check("load42", int'({bus.tens, bus.ones}), 8'h42);
        check("load42_idle", int'({bus.running, bus.done}), 0);

        // Pause mid-period, resume continues the divider
        bus.up = 1;
        pulse_start();
        steps(1);
        bus.pause = 1;
        step();
        t0 = ticks_seen;
        steps(10);
        check("pause_no_tick", ticks_seen - t0, 0);
        bus.pause = 0;
        pulse_start();
        wait_tick(20, n);
        check("resume_lat", n, 2);
        check("cnt43", int'({bus.tens, bus.ones}), 8'h43);

        // Digit carry/borrow and wrap from terminal value
        do_clr();
        do_load(8'h09); bus.up = 1; pulse_start(); wait_tick(20, n);
        check("cnt10", int'({bus.tens, bus.ones}), 8'h10);
        do_clr();
        do_load(8'h10); bus.up = 0; pulse_start(); wait_tick(20, n);
        check("cnt09", int'({bus.tens, bus.ones}), 8'h09);
        do_clr();
        do_load(8'h99); bus.up = 1; pulse_start(); wait_tick(20, n);
        check("wrap00", int'({bus.tens, bus.ones}), 8'h00);
        check("wrap_no_done", int'(bus.done), 0);

        // Random stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            bus.start  = ($urandom_range(0, 7) == 0);
            bus.pause  = ($urandom_range(0, 5) == 0);
            bus.load   = ($urandom_range(0, 9) == 0);
            bus.up     = ($urandom_range(0, 3) != 0);
            bus.preset = ($urandom_range(0, 3) != 0)
                       ? 8'({4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))})
                       : 8'($urandom);
            clr = ($urandom_range(0, 199) == 0);
            step();
            clr = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/count_ctrl.md
COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 Parameter DIV, default 50000000, clock cycles per count tick (legal range 2 or greater).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 clr  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  level; begin or resume counting (synchronous, single-cycle pulse expected).
REQ-005 pause  input  1  level; suspend counting.
REQ-006 load  input  1  level; load preset into count.
REQ-007 up  input  1  count direction: 1 = up, 0 = down; sampled at each tick.
REQ-008 preset  input  8  BCD preset: [7:4] tens, [3:0] ones.
REQ-009 tens  output  4  BCD tens digit of count.
REQ-010 ones  output  4  BCD ones digit of count.
REQ-011 tick  output  1  one-cycle pulse coincident with each count update.
REQ-012 running  output  1  high while state is RUN.
REQ-013 done  output  1  high while state is DONE.

Function
REQ-014 FSM states IDLE, RUN, PAUSE, DONE; running and done are decoded from state, with no extra latency.
REQ-015 IDLE: start moves to RUN; pause is ignored; start with load: start wins, and load is ignored.
REQ-016 RUN: pause moves to PAUSE; start and load are ignored.
REQ-017 PAUSE: start without pause moves to RUN; start with pause stays in PAUSE (pause has priority).
REQ-018 DONE: start and pause are ignored; load loads preset and moves to IDLE.
REQ-019 load in IDLE or PAUSE loads preset and keeps the state.
REQ-020 load with a preset digit greater than 9 is ignored entirely: no count change and no state change.
REQ-021 Divider counter range 0..DIV-1; width is the minimum needed to hold DIV-1.
REQ-022 The divider increments only in RUN.
REQ-023 The divider holds its value in PAUSE, so resume continues mid-period.
REQ-024 The divider clears to 0 on the IDLE->RUN transition and on any load.
REQ-025 On an edge in RUN with divider == DIV-1: divider <= 0, tick <= 1, count <= next value; otherwise tick <= 0.
REQ-026 First tick after IDLE->RUN appears exactly DIV cycles after the edge that entered RUN.
REQ-027 Up step: ones 9 -> 0 with tens+1; 99 -> 00 wraps, and the count continues.
REQ-028 Down step: ones 0 -> 9 with tens-1; 00 -> 99 wraps, and the count continues.
REQ-029 Terminal value is evaluated on the new count only: up with new count 99, or down with new count 00.
REQ-030 On the same edge the count updates to the terminal value, the state moves to DONE; done is high the same cycle as tick.
REQ-031 Starting from the terminal value does not trigger DONE; the first tick wraps (REQ-027, REQ-028).
REQ-032 A tick edge with pause asserted: the count update and tick occur, then the state moves to PAUSE; if that update is terminal, the state moves to DONE (DONE wins).
REQ-033 tens and ones never hold a value greater than 9.

Reset
REQ-034 clr asserted: state=IDLE, divider=0, tens=0, ones=0, tick=0, running=0, done=0, immediately and independently of clk.
REQ-035 clr mid-RUN or mid-PAUSE discards all progress; after release, a start is required before counting resumes.
REQ-036 Input sampling resumes on the first rising clk edge after clr deasserts.

Structure
REQ-037 Package count_ctrl_pkg holds the state enumeration (IDLE, RUN, PAUSE, DONE) and the BCD constants BCD_MAX=9, TERM_UP=8'h99, TERM_DN=8'h00.
REQ-038 One sub-module, tick_gen: parameter DIV; inputs clk, clr, en, sclr; output tick; it implements REQ-021..REQ-026.
REQ-039 The BCD step and terminal logic stay in count_ctrl.

Verification (bench uses DIV=4)
REQ-040 clr=1 for 100 ns then 0; start pulse, up=1 -> first tick 4 cycles after the RUN entry edge; count 00->01->02, one tick every 4 cycles.
REQ-041 load preset=8'h97, up=1, start -> count 98, then 99 with done=1 on that tick; afterwards no further ticks and count held at 99.
REQ-042 load 8'h01, up=0, start -> 00 and DONE; then load 8'h3A -> ignored, state stays DONE; then load 8'h42 -> count 42, state IDLE.
REQ-043 RUN, pause after 2 divider cycles, hold 10 cycles, start -> next tick exactly 2 cycles after resume; no tick during PAUSE.
REQ-044 Preset 8'h09 up gives 10 on the first tick; preset 8'h10 down gives 09; preset 8'h99 up, start -> 00 with no DONE.
REQ-045 clr asserted mid-RUN between clock edges -> all outputs 0 immediately; after release, no ticks occur until start.
